labft_fault_manager: RTL and testbench

- Sits directly downstream of the LABFT checksum checker and consumes its per-lane error vector, one verdict per checked tile.
- Decides the tile outcome:
  - pass: the tile is accepted.
  - transient: a replay is requested from the tile scheduler, and the tile then passes.
  - permanent: replays are exhausted, so a fault interrupt is raised.
- Keeps saturating per-lane error statistics and a first-fault capture for software.

---
 rtl/labft_pkg.sv | 18 +
 rtl/labft_sat_counter.sv | 38 +++
 rtl/labft_fault_manager.sv | 160 ++++++++++++++++
 tb/tb_labft_fault_manager.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/labft_pkg.sv
// Shared types and helpers for the LABFT fault manager.
package labft_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REPLAY = 2'd1,
        WAIT   = 2'd2,
        FAULT  = 2'd3
    } state_e;

    localparam int unsigned RETRY_W = 3;

    // Increment that sticks at maxv; callers zero-extend into 32 bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] maxv);
        return (v == maxv) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/labft_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module labft_sat_counter
    import labft_pkg::*;
#(
    parameter int unsigned width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [width-1:0] count
);

    logic [width-1:0] count_q;
    logic [width-1:0] count_d;
    logic [width-1:0] inc_val;

    always_comb begin
        inc_val = width'(sat_inc(32'(count_q), 32'({width{1'b1}})));
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = inc_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/labft_fault_manager.sv
// Consumes LABFT checker verdicts: accepts tiles, requests replays, raises faults,
// and keeps per-lane error statistics plus a first-fault capture.
module labft_fault_manager
    import labft_pkg::*;
#(
    parameter int unsigned lanes       = 4,
    parameter int unsigned countWidth  = 16,
    parameter int unsigned maxRetries  = 2,
    parameter int unsigned tileIdWidth = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        check_valid,
    input  logic [lanes-1:0]            error,
    output logic                        replay_req,
    output logic [lanes-1:0]            replay_lane_mask,
    input  logic                        replay_ack,
    output logic                        tile_ok,
    output logic                        fault_irq,
    input  logic                        irq_clear,
    output logic [1:0]                  state,
    output logic [tileIdWidth-1:0]      tile_count,
    output logic [lanes*countWidth-1:0] err_count,
    output logic [countWidth-1:0]       recovered_count,
    output logic                        first_fault_valid,
    output logic [tileIdWidth-1:0]      first_fault_tile,
    output logic [lanes-1:0]            first_fault_mask
);

    state_e                 state_q;
    logic [RETRY_W-1:0]     retry_q;
    logic                   replay_req_q;
    logic [lanes-1:0]       mask_q;
    logic                   tile_ok_q;
    logic                   fault_irq_q;
    logic [tileIdWidth-1:0] tile_count_q;
    logic                   ffv_q;
    logic [tileIdWidth-1:0] fft_q;
    logic [lanes-1:0]       ffm_q;

    logic any_err;
    logic stats_en;
    logic capture;
    logic rec_inc;

    assign any_err  = (error != '0);
    assign stats_en = check_valid && (state_q != FAULT);
    assign capture  = stats_en && any_err && !ffv_q;
    assign rec_inc  = check_valid && (state_q == WAIT) && !any_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            retry_q      <= '0;
            replay_req_q <= 1'b0;
            mask_q       <= '0;
            tile_ok_q    <= 1'b0;
            fault_irq_q  <= 1'b0;
            tile_count_q <= '0;
        end else begin
            tile_ok_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (check_valid) begin
                        if (!any_err) begin
                            tile_ok_q    <= 1'b1;
                            tile_count_q <= tile_count_q + 1'b1;
                        end else begin
                            retry_q      <= RETRY_W'(1);
                            mask_q       <= error;
                            replay_req_q <= 1'b1;
                            state_q      <= REPLAY;
                        end
                    end
                end
                REPLAY: begin
                    if (replay_ack) begin
                        replay_req_q <= 1'b0;
                        mask_q       <= '0;
                        state_q      <= WAIT;
                    end
                end
                WAIT: begin
                    if (check_valid) begin
                        if (!any_err) begin
                            tile_ok_q    <= 1'b1;
                            tile_count_q <= tile_count_q + 1'b1;
                            retry_q      <= '0;
                            state_q      <= IDLE;
                        end else if (retry_q < RETRY_W'(maxRetries)) begin
                            retry_q      <= retry_q + 1'b1;
                            mask_q       <= error;
                            replay_req_q <= 1'b1;
                            state_q      <= REPLAY;
                        end else begin
                            fault_irq_q  <= 1'b1;
                            state_q      <= FAULT;
                        end
                    end
                end
                FAULT: begin
                    if (irq_clear) begin
                        retry_q     <= '0;
                        fault_irq_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Capture data is kept across irq_clear; only the valid flag is cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ffv_q <= 1'b0;
            fft_q <= '0;
            ffm_q <= '0;
        end else begin
            if (capture) begin
                fft_q <= tile_count_q;
                ffm_q <= error;
            end
            if (irq_clear) begin
                ffv_q <= 1'b0;
            end else if (capture) begin
                ffv_q <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < int'(lanes); i++) begin : g_lane
        labft_sat_counter #(.width(countWidth)) u_err_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (stats_en && error[i]),
            .clr   (1'b0),
            .count (err_count[i*countWidth +: countWidth])
        );
    end

    labft_sat_counter #(.width(countWidth)) u_rec_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (rec_inc),
        .clr   (1'b0),
        .count (recovered_count)
    );

    assign state             = state_q;
    assign replay_req        = replay_req_q;
    assign replay_lane_mask  = mask_q;
    assign tile_ok           = tile_ok_q;
    assign fault_irq         = fault_irq_q;
    assign tile_count        = tile_count_q;
    assign first_fault_valid = ffv_q;
    assign first_fault_tile  = fft_q;
    assign first_fault_mask  = ffm_q;

endmodule

// File: tb/tb_labft_fault_manager.sv
// Vector-table bench with an expected-result queue for labft_fault_manager.
module tb_labft_fault_manager;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        check_valid = 1'b0;
    logic [3:0]  error = '0;
    logic        replay_ack = 1'b0;
    logic        irq_clear = 1'b0;
    logic        replay_req;
    logic [3:0]  replay_lane_mask;
    logic        tile_ok;
    logic        fault_irq;
    logic [1:0]  state;
    logic [15:0] tile_count;
    logic [63:0] err_count;
    logic [15:0] recovered_count;
    logic        first_fault_valid;
    logic [15:0] first_fault_tile;
    logic [3:0]  first_fault_mask;

    labft_fault_manager #(
        .lanes(4), .countWidth(16), .maxRetries(2), .tileIdWidth(16)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .check_valid       (check_valid),
        .error             (error),
        .replay_req        (replay_req),
        .replay_lane_mask  (replay_lane_mask),
        .replay_ack        (replay_ack),
        .tile_ok           (tile_ok),
        .fault_irq         (fault_irq),
        .irq_clear         (irq_clear),
        .state             (state),
        .tile_count        (tile_count),
        .err_count         (err_count),
        .recovered_count   (recovered_count),
        .first_fault_valid (first_fault_valid),
        .first_fault_tile  (first_fault_tile),
        .first_fault_mask  (first_fault_mask)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        cv;
        logic [3:0]  err;
        logic        ack;
        logic        clr;
        logic [1:0]  st;
        logic        rq;
        logic [3:0]  msk;
        logic        ok;
        logic        irq;
        logic [15:0] tc;
        logic [63:0] ec;
        logic [15:0] rc;
        logic        ffv;
        logic [15:0] fft;
        logic [3:0]  ffm;
    } vec_t;

    vec_t        exp_q[$];
    vec_t        tab_a[$];
    vec_t        tab_b[$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    function automatic vec_t mk(
        input logic cv, input logic [3:0] err, input logic ack, input logic clr,
        input logic [1:0] st, input logic rq, input logic [3:0] msk, input logic ok,
        input logic irq, input logic [15:0] tc, input logic [63:0] ec,
        input logic [15:0] rc, input logic ffv, input logic [15:0] fft, input logic [3:0] ffm);
        vec_t v;
        v.cv = cv;  v.err = err; v.ack = ack; v.clr = clr;
        v.st = st;  v.rq = rq;   v.msk = msk; v.ok = ok;  v.irq = irq;
        v.tc = tc;  v.ec = ec;   v.rc = rc;
        v.ffv = ffv; v.fft = fft; v.ffm = ffm;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic compare_out(input int unsigned idx, input vec_t e);
        string t;
        t = $sformatf("[%0d]", idx);
        chk({"state", t},      64'(state),             64'(e.st));
        chk({"replay_req", t}, 64'(replay_req),        64'(e.rq));
        chk({"mask", t},       64'(replay_lane_mask),  64'(e.msk));
        chk({"tile_ok", t},    64'(tile_ok),           64'(e.ok));
        chk({"fault_irq", t},  64'(fault_irq),         64'(e.irq));
        chk({"tile_count", t}, 64'(tile_count),        64'(e.tc));
        chk({"err_count", t},  err_count,              e.ec);
        chk({"recovered", t},  64'(recovered_count),   64'(e.rc));
        chk({"ff_valid", t},   64'(first_fault_valid), 64'(e.ffv));
        chk({"ff_tile", t},    64'(first_fault_tile),  64'(e.fft));
        chk({"ff_mask", t},    64'(first_fault_mask),  64'(e.ffm));
    endtask

    task automatic apply(input int unsigned idx, input vec_t v);
        vec_t e;
        @(negedge clk);
        check_valid = v.cv;
        error       = v.err;
        replay_ack  = v.ack;
        irq_clear   = v.clr;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            compare_out(idx, e);
        end
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_replay_req"}, 64'(replay_req), 64'd0);
        chk({name, "_state"},      64'(state),      64'd0);
        chk({name, "_outs"},
            64'({replay_lane_mask, tile_ok, fault_irq, tile_count, recovered_count,
                 first_fault_valid, first_fault_tile, first_fault_mask}), 64'd0);
        chk({name, "_err_count"}, err_count, 64'd0);
    endtask

    localparam logic [63:0] E2  = 64'h0000_0001_0000_0000;
    localparam logic [63:0] E5  = 64'h0000_0001_FFFF_0003;

    initial begin
        // Pass, replay-then-pass, exhausted retries, fault clear, IDLE ack ignored.
        tab_a.push_back(mk(1, 4'h0, 0, 0, 2'd0, 0, 4'h0, 1, 0, 16'd1, 64'd0, 16'd0, 0, 16'd0, 4'h0));
        tab_a.push_back(mk(1, 4'h0, 0, 0, 2'd0, 0, 4'h0, 1, 0, 16'd2, 64'd0, 16'd0, 0, 16'd0, 4'h0));
        tab_a.push_back(mk(1, 4'h0, 0, 0, 2'd0, 0, 4'h0, 1, 0, 16'd3, 64'd0, 16'd0, 0, 16'd0, 4'h0));
        tab_a.push_back(mk(0, 4'h0, 0, 0, 2'd0, 0, 4'h0, 0, 0, 16'd3, 64'd0, 16'd0, 0, 16'd0, 4'h0));
        tab_a.push_back(mk(1, 4'h4, 0, 0, 2'd1, 1, 4'h4, 0, 0, 16'd3, E2, 16'd0, 1, 16'd3, 4'h4));
        tab_a.push_back(mk(0, 4'h0, 1, 0, 2'd2, 0, 4'h0, 0, 0, 16'd3, E2, 16'd0, 1, 16'd3, 4'h4));
        tab_a.push_back(mk(1, 4'h0, 0, 0, 2'd0, 0, 4'h0, 1, 0, 16'd4, E2, 16'd1, 1, 16'd3, 4'h4));
        tab_a.push_back(mk(0, 4'h0, 0, 0, 2'd0, 0, 4'h0, 0, 0, 16'd4, E2, 16'd1, 1, 16'd3, 4'h4));
        tab_a.push_back(mk(1, 4'h1, 0, 0, 2'd1, 1, 4'h1, 0, 0, 16'd4, 64'h0000_0001_0000_0001, 16'd1, 1, 16'd3, 4'h4));
        tab_a.push_back(mk(0, 4'h0, 1, 0, 2'd2, 0, 4'h0, 0, 0, 16'd4, 64'h0000_0001_0000_0001, 16'd1, 1, 16'd3, 4'h4));
        tab_a.push_back(mk(1, 4'h1, 0, 0, 2'd1, 1, 4'h1, 0, 0, 16'd4, 64'h0000_0001_0000_0002, 16'd1, 1, 16'd3, 4'h4));
        tab_a.push_back(mk(0, 4'h0, 1, 0, 2'd2, 0, 4'h0, 0, 0, 16'd4, 64'h0000_0001_0000_0002, 16'd1, 1, 16'd3, 4'h4));
        tab_a.push_back(mk(1, 4'h1, 0, 0, 2'd3, 0, 4'h0, 0, 1, 16'd4, 64'h0000_0001_0000_0003, 16'd1, 1, 16'd3, 4'h4));
        tab_a.push_back(mk(1, 4'hF, 0, 0, 2'd3, 0, 4'h0, 0, 1, 16'd4, 64'h0000_0001_0000_0003, 16'd1, 1, 16'd3, 4'h4));
        tab_a.push_back(mk(1, 4'hF, 0, 1, 2'd0, 0, 4'h0, 0, 0, 16'd4, 64'h0000_0001_0000_0003, 16'd1, 0, 16'd3, 4'h4));
        tab_a.push_back(mk(0, 4'h0, 1, 0, 2'd0, 0, 4'h0, 0, 0, 16'd4, 64'h0000_0001_0000_0003, 16'd1, 0, 16'd3, 4'h4));
        tab_a.push_back(mk(1, 4'h2, 0, 0, 2'd1, 1, 4'h2, 0, 0, 16'd4, 64'h0000_0001_0001_0003, 16'd1, 1, 16'd4, 4'h2));

        // Lane 1 saturation, ack beating a simultaneous check, recovery, then a fresh replay.
        tab_b.push_back(mk(1, 4'h2, 0, 0, 2'd1, 1, 4'h2, 0, 0, 16'd4, E5, 16'd1, 1, 16'd4, 4'h2));
        tab_b.push_back(mk(1, 4'h2, 0, 0, 2'd1, 1, 4'h2, 0, 0, 16'd4, E5, 16'd1, 1, 16'd4, 4'h2));
        tab_b.push_back(mk(1, 4'h2, 1, 0, 2'd2, 0, 4'h0, 0, 0, 16'd4, E5, 16'd1, 1, 16'd4, 4'h2));
        tab_b.push_back(mk(1, 4'h0, 0, 0, 2'd0, 0, 4'h0, 1, 0, 16'd5, E5, 16'd2, 1, 16'd4, 4'h2));
        tab_b.push_back(mk(1, 4'h8, 0, 0, 2'd1, 1, 4'h8, 0, 0, 16'd5, 64'h0001_0001_FFFF_0003, 16'd2, 1, 16'd4, 4'h2));

        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int unsigned i = 0; i < tab_a.size(); i++) apply(i, tab_a[i]);

        // Stay in REPLAY and keep checking lane 1 to walk its counter up to 0xFFFE.
        @(negedge clk);
        check_valid = 1'b1;
        error       = 4'h2;
        replay_ack  = 1'b0;
        irq_clear   = 1'b0;
        repeat (65533) @(posedge clk);
        #1;
        chk("lane1_preload", 64'(err_count[31:16]), 64'h0000_0000_0000_FFFE);
        chk("preload_state", 64'(state), 64'd1);

        for (int unsigned i = 0; i < tab_b.size(); i++) apply(100 + i, tab_b[i]);

        chk("pre_reset_replay_req", 64'(replay_req), 64'd1);
        check_valid = 1'b0;
        error       = 4'h0;
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b1;
        apply(200, mk(0, 4'h0, 0, 0, 2'd0, 0, 4'h0, 0, 0, 16'd0, 64'd0, 16'd0, 0, 16'd0, 4'h0));
        apply(201, mk(1, 4'h0, 0, 0, 2'd0, 0, 4'h0, 1, 0, 16'd1, 64'd0, 16'd0, 0, 16'd0, 4'h0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
